// File: rtl/vec_dot_sequencer.sv
// Replays one stored FIFO vector per weight row and emits a signed int8 dot product per row.
// Handshakes: a beat transfers when wt_valid & wt_ready, a result when res_valid & res_ready.
module vec_dot_sequencer #(
    parameter int VecElements  = 16,
    parameter int BytesPerRead = 4,
    parameter int Rows         = 8,
    parameter int AccWidth     = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start,
    input  logic [BytesPerRead*8-1:0] rd_data,
    output logic                      rd_en,
    output logic                      wrap_rd,
    input  logic [BytesPerRead*8-1:0] wt_data,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    output logic [AccWidth-1:0]       res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                fsm_state
);

    localparam int Chunks = VecElements / BytesPerRead;
    localparam int CW     = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int RW     = (Rows > 1) ? $clog2(Rows) : 1;
    localparam logic [CW-1:0] LastChunk = CW'(Chunks - 1);
    localparam logic [RW-1:0] LastRow   = RW'(Rows - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                      state, next_state;
    logic [CW-1:0]               chunk;
    logic [RW-1:0]               row;
    logic signed [AccWidth-1:0]  acc;
    logic signed [AccWidth-1:0]  partial;
    logic signed [AccWidth-1:0]  acc_sum;
    logic signed [15:0]          prod;
    logic                        beat;
    logic                        last_chunk;
    logic                        last_row;

    assign beat       = (state == RUN) && wt_valid;
    assign last_chunk = (chunk == LastChunk);
    assign last_row   = (row == LastRow);
    assign acc_sum    = acc + partial;

    assign wt_ready  = (state == RUN);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    // The final chunk of the last row steps the FIFO on to the next vector instead of rewinding.
    assign rd_en     = beat && (!last_chunk || last_row);
    assign wrap_rd   = beat && last_chunk && !last_row;

    always_comb begin
        partial = '0;
        prod    = '0;
        for (int i = 0; i < BytesPerRead; i++) begin
            prod    = $signed(rd_data[8*i +: 8]) * $signed(wt_data[8*i +: 8]);
            partial = partial + AccWidth'(prod);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (beat && last_chunk) next_state = EMIT;
            EMIT: if (res_ready) next_state = last_row ? IDLE : RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            chunk     <= '0;
            row       <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        chunk <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (last_chunk) begin
                            res_data  <= acc_sum;
                            res_valid <= 1'b1;
                            acc       <= '0;
                        end else begin
                            acc   <= acc_sum;
                            chunk <= chunk + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (last_row) begin
                            done <= 1'b1;
                        end else begin
                            row   <= row + 1'b1;
                            chunk <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_sequencer.sv
// Directed bench for vec_dot_sequencer with a behavioural byte-vector FIFO model
// and a small AccWidth=16 instance for the modulo-wrap case.
module tb_vec_dot_sequencer;

    localparam int VE   = 8;
    localparam int BPR  = 4;
    localparam int ROWS = 2;
    localparam int C    = VE / BPR;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rd_data;
    logic        rd_en, wrap_rd;
    logic [31:0] wt_data = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy, done;
    logic [1:0]  fsm_state;

    logic        start2 = 1'b0;
    logic [31:0] rd_data2 = 32'h8080_8080;
    logic [31:0] wt_data2 = 32'h8080_8080;
    logic        wt_valid2 = 1'b0;
    logic        res_ready2 = 1'b0;
    logic        rd_en2, wrap_rd2, wt_ready2, res_valid2, busy2, done2;
    logic [15:0] res_data2;
    logic [1:0]  fsm_state2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_ptr;
    logic [7:0] fifo_mem [0:63];
    logic [1:0] ctrl_q [$];

    always #5 clk_in = ~clk_in;

    vec_dot_sequencer #(.VecElements(VE), .BytesPerRead(BPR), .Rows(ROWS), .AccWidth(32)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start), .rd_data(rd_data),
        .rd_en(rd_en), .wrap_rd(wrap_rd), .wt_data(wt_data), .wt_valid(wt_valid),
        .wt_ready(wt_ready), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    vec_dot_sequencer #(.VecElements(VE), .BytesPerRead(BPR), .Rows(1), .AccWidth(16)) u_wrap (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start2), .rd_data(rd_data2),
        .rd_en(rd_en2), .wrap_rd(wrap_rd2), .wt_data(wt_data2), .wt_valid(wt_valid2),
        .wt_ready(wt_ready2), .res_data(res_data2), .res_valid(res_valid2),
        .res_ready(res_ready2), .busy(busy2), .done(done2), .fsm_state(fsm_state2)
    );

    // FIFO model: chunk-granular read pointer over a preloaded byte store
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BPR; i++) rd_data[8*i +: 8] = fifo_mem[(rd_ptr * BPR + i) % 64];
    end

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rd_ptr <= 0;
        else if (rd_en) rd_ptr <= rd_ptr + 1;
        else if (wrap_rd) rd_ptr <= rd_ptr - (C - 1);
    end

    always @(posedge clk_in) begin
        if (rst_n_in) begin
            if (rd_en) ctrl_q.push_back(2'd1);
            if (wrap_rd) ctrl_q.push_back(2'd2);
            if (done) done_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wt_chunk(input int r, input int c);
        logic [31:0] w;
        for (int i = 0; i < BPR; i++) w[8*i +: 8] = (r == 0) ? 8'(c * BPR + 1 + i) : 8'hFF;
        return w;
    endfunction

    task automatic do_pass(input int vec_val, input int bp, input bit stall, input bit poke, input string tag);
        int exp_res [ROWS];
        int d0;
        logic [7:0] seq;
        exp_res[0] = 36 * vec_val;
        exp_res[1] = -8 * vec_val;
        ctrl_q.delete();
        d0 = done_cnt;
        @(negedge clk_in);
        check_eq({tag, " idle busy"}, busy, 0);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check_eq({tag, " busy after start"}, busy, 1);
        check_eq({tag, " state run"}, fsm_state, 1);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < C; c++) begin
                if (stall && c == 1) begin
                    wt_valid = 1'b0;
                    repeat (2) begin
                        #1 check_eq({tag, " gap ctrl"}, {wrap_rd, rd_en}, 0);
                        @(negedge clk_in);
                    end
                end
                if (poke && r == 0 && c == 1) start = 1'b1;
                wt_valid = 1'b1;
                wt_data  = wt_chunk(r, c);
                #1 check_eq({tag, " beat ctrl"}, {wrap_rd, rd_en},
                            (c < C - 1) ? 1 : ((r < ROWS - 1) ? 2 : 1));
                check_eq({tag, " wt_ready"}, wt_ready, 1);
                @(negedge clk_in);
                start = 1'b0;
            end
            wt_valid = 1'b0;
            #1 check_eq({tag, " res_valid"}, res_valid, 1);
            check_eq({tag, " res_data"}, res_data, exp_res[r]);
            check_eq({tag, " state emit"}, fsm_state, 2);
            if (poke) start = 1'b1;
            if (bp > 0 && r == 0) begin
                wt_valid = 1'b1;
                wt_data  = 32'hDEAD_BEEF;
                repeat (bp) begin
                    @(negedge clk_in);
                    check_eq({tag, " bp hold valid"}, res_valid, 1);
                    check_eq({tag, " bp hold data"}, res_data, exp_res[r]);
                    check_eq({tag, " bp quiet"}, {wt_ready, wrap_rd, rd_en}, 0);
                end
                wt_valid = 1'b0;
            end
            res_ready = 1'b1;
            @(negedge clk_in);
            res_ready = 1'b0;
            start = 1'b0;
            check_eq({tag, " res_valid drop"}, res_valid, 0);
            if (r == ROWS - 1) begin
                check_eq({tag, " done pulse"}, done, 1);
                check_eq({tag, " busy end"}, busy, 0);
                @(negedge clk_in);
                check_eq({tag, " done low"}, done, 0);
                check_eq({tag, " state idle"}, fsm_state, 0);
            end
        end
        repeat (3) @(negedge clk_in);
        check_eq({tag, " no extra pass"}, busy, 0);
        check_eq({tag, " done count"}, done_cnt - d0, 1);
        seq = '0;
        foreach (ctrl_q[i]) seq = {seq[5:0], ctrl_q[i]};
        check_eq({tag, " ctrl count"}, ctrl_q.size(), 4);
        check_eq({tag, " ctrl seq"}, seq, 8'b01_10_01_01);
    endtask

    initial begin
        // vector k holds bytes all equal to k+1
        for (int v = 0; v < 8; v++)
            for (int b = 0; b < VE; b++) fifo_mem[v * VE + b] = 8'(v + 1);

        #12;
        check_eq("reset rd_en", rd_en, 0);
        check_eq("reset wrap_rd", wrap_rd, 0);
        check_eq("reset wt_ready", wt_ready, 0);
        check_eq("reset res_valid", res_valid, 0);
        check_eq("reset res_data", res_data, 0);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset state", fsm_state, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        do_pass(1, 0, 1'b0, 1'b0, "basic");
        do_pass(2, 5, 1'b0, 1'b0, "backpressure");
        do_pass(3, 0, 1'b1, 1'b0, "stall");
        do_pass(4, 0, 1'b0, 1'b1, "start_busy");

        // reset mid-row with a beat on the wire, away from any clock edge
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wt_valid = 1'b1;
        wt_data  = wt_chunk(0, 0);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check_eq("arst rd_en", rd_en, 0);
        check_eq("arst wrap_rd", wrap_rd, 0);
        check_eq("arst wt_ready", wt_ready, 0);
        check_eq("arst res_valid", res_valid, 0);
        check_eq("arst res_data", res_data, 0);
        check_eq("arst busy", busy, 0);
        check_eq("arst done", done, 0);
        wt_valid = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        do_pass(1, 0, 1'b0, 1'b0, "after_reset");

        // AccWidth=16: 8 x (-128 * -128) = 131072 wraps to zero
        @(negedge clk_in);
        start2 = 1'b1;
        @(negedge clk_in);
        start2 = 1'b0;
        wt_valid2 = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        wt_valid2 = 1'b0;
        #1 check_eq("wrap res_valid", res_valid2, 1);
        check_eq("wrap res_data", 32'(res_data2), 0);
        res_ready2 = 1'b1;
        @(negedge clk_in);
        res_ready2 = 1'b0;
        check_eq("wrap done", done2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
